// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, sequencer states and control-strobe bundle shared by the core
package cpu_pkg;
    localparam int OPW    = 3;
    localparam int STATEW = 4;

    localparam logic [OPW-1:0] HLT  = 3'b000;
    localparam logic [OPW-1:0] SKZ  = 3'b001;
    localparam logic [OPW-1:0] ADD  = 3'b010;
    localparam logic [OPW-1:0] ANDD = 3'b011;
    localparam logic [OPW-1:0] XORR = 3'b100;
    localparam logic [OPW-1:0] LDA  = 3'b101;
    localparam logic [OPW-1:0] STO  = 3'b110;
    localparam logic [OPW-1:0] JMP  = 3'b111;

    typedef enum logic [STATEW-1:0] {IDLE, HALT, S0, S1, S2, S3, S4, S5, S6, S7} state_t;

    typedef struct packed {
        logic rd;
        logic wr;
        logic load_ir;
        logic inc_pc;
        logic load_pc;
        logic load_acc;
        logic alu_ena;
        logic datactl_ena;
        logic halt;
    } ctl_t;

    function automatic logic is_alu(input logic [OPW-1:0] op);
        return op inside {ADD, ANDD, XORR, LDA};
    endfunction
endpackage

// File: rtl/machine_seq.sv
// machine_seq: 8-phase instruction-cycle sequencer with registered control strobes.
// Define SEQ_INSTR_CNT_EN to add the saturating instr_cnt output.
module machine_seq
    import cpu_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic           rd,
    output logic           wr,
    output logic           load_ir,
    output logic           inc_pc,
    output logic           load_pc,
    output logic           load_acc,
    output logic           alu_ena,
    output logic           datactl_ena,
    output logic           halt
`ifdef SEQ_INSTR_CNT_EN
    ,output logic [15:0]   instr_cnt
`endif
);
    state_t state_q, state_d;
    ctl_t   ctl_q, ctl_d;

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = S0;
            HALT:    state_d = HALT;
            S0:      state_d = S1;
            S1:      state_d = S2;
            S2:      state_d = S3;
            S3:      state_d = (opcode == HLT) ? HALT : S4;
            S4:      state_d = S5;
            S5:      state_d = S6;
            S6:      state_d = S7;
            S7:      state_d = S0;
            default: state_d = IDLE;
        endcase
        if (!ena)
            state_d = IDLE;
        // strobes are decoded from the state being entered so they line up with it
        ctl_d = '0;
        case (state_d)
            S0: begin
                ctl_d.rd      = 1'b1;
                ctl_d.load_ir = 1'b1;
            end
            S1: begin
                ctl_d.rd      = 1'b1;
                ctl_d.load_ir = 1'b1;
                ctl_d.inc_pc  = 1'b1;
            end
            S3: begin
                ctl_d.halt   = (opcode == HLT);
                ctl_d.inc_pc = (opcode != HLT);
            end
            S4: begin
                ctl_d.rd          = is_alu(opcode);
                ctl_d.alu_ena     = is_alu(opcode);
                ctl_d.datactl_ena = (opcode == STO);
                ctl_d.load_pc     = (opcode == JMP);
                ctl_d.inc_pc      = (opcode == SKZ) && zero;
            end
            S5: begin
                ctl_d.rd          = is_alu(opcode);
                ctl_d.load_acc    = is_alu(opcode);
                ctl_d.wr          = (opcode == STO);
                ctl_d.datactl_ena = (opcode == STO);
                ctl_d.load_pc     = (opcode == JMP);
            end
            S6: begin
                ctl_d.datactl_ena = (opcode == STO);
                ctl_d.inc_pc      = (opcode == SKZ) && zero;
            end
            HALT:    ctl_d.halt = 1'b1;
            default: ctl_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
        end
    end

    assign rd          = ctl_q.rd;
    assign wr          = ctl_q.wr;
    assign load_ir     = ctl_q.load_ir;
    assign inc_pc      = ctl_q.inc_pc;
    assign load_pc     = ctl_q.load_pc;
    assign load_acc    = ctl_q.load_acc;
    assign alu_ena     = ctl_q.alu_ena;
    assign datactl_ena = ctl_q.datactl_ena;
    assign halt        = ctl_q.halt;

`ifdef SEQ_INSTR_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // S7 only ever leaves to S0 or IDLE, so every exit from S7 completes an instruction
    always_comb cnt_d = (state_q == S7 && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign instr_cnt = cnt_q;
`endif
endmodule

// File: doc/machine_seq.md
Name: machine_seq

Overview:
- Instruction-cycle sequencer for the 8-bit accumulator RISC core. It sits directly upstream of the ALU and drives alu_ena to it.
- Steps a fixed 8-phase cycle, S0..S7, per instruction. Each instruction is two bytes (opcode+addr-high, addr-low).
- Issues memory, PC, IR, accumulator, ALU and data-bus control strobes, decoded from the 3-bit opcode held in the IR.

Parameters:
- OPW, 3, opcode width. Fixed by the ISA; any other value is illegal.
- STATEW, 4, state register width. Covers IDLE, HALT and S0..S7.

Ports:
- clk  input  1  system clock; all flops on posedge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  run enable from the start/control latch.
- opcode  input  OPW  opcode from the instruction register. Stable from S2 through S7.
- zero  input  1  accumulator-is-zero flag (the ALU's zero output).
- rd  output  1  memory read strobe.
- wr  output  1  memory write strobe.
- load_ir  output  1  IR byte load.
- inc_pc  output  1  PC increment.
- load_pc  output  1  PC load from IR address field.
- load_acc  output  1  accumulator load from alu_out.
- alu_ena  output  1  ALU result register enable.
- datactl_ena  output  1  drive accumulator onto the data bus.
- halt  output  1  core halted indicator.

Behaviour:
- Reset: state = IDLE; every output = 0, asynchronously on rst_n low.
- All outputs are registered. Each output takes its listed value on the same edge that enters the state, and holds it for exactly that state's cycle.
- Any strobe not listed for a state is 0 in that state.
- IDLE: outputs 0. ena=1 -> S0, else stay.
- ena=0 in any state other than IDLE -> IDLE on the next edge, with all outputs 0. This aborts mid-instruction; no partial write completes after the abort edge.
- S0: rd=1, load_ir=1 (fetch high byte). -> S1.
- S1: rd=1, load_ir=1, inc_pc=1 (fetch low byte). -> S2.
- S2: all outputs 0 (IR settle). -> S3.
- S3:
  - HLT: halt=1, then -> HALT.
  - Any other opcode: inc_pc=1, then -> S4.
- S4:
  - ADD/ANDD/XORR/LDA: rd=1, alu_ena=1.
  - STO: datactl_ena=1.
  - JMP: load_pc=1.
  - SKZ: inc_pc=zero, with zero sampled at the edge entering S4.
  - -> S5.
- S5:
  - ADD/ANDD/XORR/LDA: rd=1, load_acc=1.
  - STO: wr=1, datactl_ena=1.
  - JMP: load_pc=1.
  - SKZ: all 0.
  - -> S6.
- S6:
  - STO: datactl_ena=1 (data hold after wr).
  - SKZ: inc_pc=zero, with zero sampled at the edge entering S6.
  - Others: all 0.
  - -> S7.
- S7: all 0. -> S0 if ena=1, else IDLE.
- HALT: halt=1 held, all other outputs 0. Exit only via ena=0 -> IDLE.
- PC net advance per instruction:
  - Normal instruction: +2 (S1, S3).
  - SKZ with zero=1: +4 (S1, S3, S4, S6).
  - JMP: load_pc asserted for exactly 2 cycles.
- Strobe constraints:
  - wr is never asserted in the same cycle as rd.
  - wr is always bracketed by datactl_ena on the preceding cycle and the following cycle.
- Undefined or illegal state encoding -> IDLE on the next edge.

Optional Feature:
- Macro: SEQ_INSTR_CNT_EN.
- Defined:
  - Adds output instr_cnt [15:0], reset 0.
  - Increments on each S7 -> S0 or S7 -> IDLE transition.
  - Saturates at 16'hFFFF. Unaffected by HALT and by abort.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package cpu_pkg:
  - Opcode localparams: HLT=000, SKZ=001, ADD=010, ANDD=011, XORR=100, LDA=101, STO=110, JMP=111. These are shared with the ALU.
  - Sequencer state encoding: IDLE, HALT, S0..S7.
- No sub-module. Next-state logic, output decode and the optional counter stay inline in machine_seq.

Test Plan:
- Reset and idle: rst_n low with ena=1 -> state IDLE, all outputs 0. Release rst_n with ena=0 -> stays IDLE for 10 cycles, outputs 0.
- ADD cycle: ena=1, opcode=010 -> rd on S0, S1, S4, S5; load_ir on S0, S1; inc_pc on S1, S3; alu_ena on S4 only; load_acc on S5 only; returns to S0 after 8 cycles.
- STO cycle: opcode=110 -> datactl_ena on S4, S5, S6; wr on S5 only; rd never asserted in S4..S7.
- SKZ: opcode=001 with zero=1 -> 4 inc_pc pulses in 8 cycles. With zero=0 -> exactly 2 pulses (S1, S3).
- HLT and abort: opcode=000 -> halt rises entering S3 and holds. Dropping ena -> IDLE, halt=0 next cycle. Separately, ena dropped in S4 of a STO -> no wr pulse ever appears.
- With SEQ_INSTR_CNT_EN: run 3 ADD instructions -> instr_cnt=3. Preload the counter near 16'hFFFF (force) -> it holds at 16'hFFFF.
